risc16_fetch_bp: RTL

- Instruction-fetch front end with branch prediction. It sits directly upstream of the RISC16 decode/register-fetch stage.
- Drives the instruction-memory address and registers the fetched word together with its PC and a prediction.
- Predicts taken/not-taken with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. The table is trained by branch/jump resolutions from the EX stage.
- On a misprediction the EX stage supplies the corrected next PC; the block redirects and emits one bubble.

---
 rtl/risc16_fetch_bp.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/risc16_fetch_bp.sv
// RISC16 instruction-fetch front end with a direct-mapped BTB of 2-bit
// saturating counters. Trained by EX-stage resolutions; a mispredict
// redirects the PC and drops one bubble into decode.

// One BTB entry: valid, tag, target, 2-bit counter, trained in place.
module risc16_btb_entry #(
  parameter int TAG_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic             upd_taken,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [15:0]      upd_target,
  output logic             vld,
  output logic [TAG_W-1:0] tag,
  output logic [15:0]      target,
  output logic [1:0]       ctr
);

  logic hit;
  assign hit = vld && (tag == upd_tag);

  // Hit: saturating counter walk, and a refreshed target on taken.
  // Miss: a taken resolution allocates weakly-taken; not-taken leaves the entry alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'b01;
    end else if (upd) begin
      if (hit) begin
        if (upd_taken) begin
          if (ctr != 2'b11) ctr <= ctr + 2'd1;
          target <= upd_target;
        end else if (ctr != 2'b00) begin
          ctr <= ctr - 2'd1;
        end
      end else if (upd_taken) begin
        vld    <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        ctr    <= 2'b10;
      end
    end
  end

endmodule

module risc16_fetch_bp #(
  parameter int          IDX_W  = 6,
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] iaddr,
  output logic        ioe,
  input  logic [15:0] idin,
  input  logic        stall,
  output logic        fe_valid,
  output logic [15:0] fe_ir,
  output logic [15:0] fe_pc,
  output logic        fe_pred_taken,
  output logic [15:0] fe_pred_target,
  input  logic        rs_valid,
  input  logic [15:0] rs_pc,
  input  logic        rs_taken,
  input  logic [15:0] rs_target,
  input  logic        rs_mispredict,
  input  logic [15:0] rs_next_pc
);

  localparam int NENT  = 1 << IDX_W;
  localparam int TAG_W = 15 - IDX_W;

  typedef struct packed {
    logic        valid;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        pred_taken;
    logic [15:0] pred_target;
  } fe_t;

  logic [15:0] pc, pc_nxt;
  fe_t         fe_q;

  logic [NENT-1:0]             e_vld;
  logic [NENT-1:0][TAG_W-1:0]  e_tag;
  logic [NENT-1:0][15:0]       e_tgt;
  logic [NENT-1:0][1:0]        e_ctr;

  logic [IDX_W-1:0] lk_idx, rs_idx;
  logic             hit, pred, redirect;
  logic [15:0]      pred_tgt;
  logic             unused;

  assign iaddr  = pc;
  assign ioe    = 1'b1;
  assign unused = rs_pc[0];

  assign lk_idx   = pc[IDX_W:1];
  assign rs_idx   = rs_pc[IDX_W:1];
  assign hit      = e_vld[lk_idx] && (e_tag[lk_idx] == pc[15:IDX_W+1]);
  assign pred     = hit && e_ctr[lk_idx][1];
  assign pred_tgt = e_tgt[lk_idx];
  assign redirect = rs_valid && rs_mispredict;

  // Lookup reads the registered entries, so a same-cycle update on the
  // same index is only seen from the following cycle.
  for (genvar gi = 0; gi < NENT; gi++) begin : g_btb
    localparam logic [IDX_W-1:0] IDX = gi;
    risc16_btb_entry #(.TAG_W(TAG_W)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .upd        (rs_valid && (rs_idx == IDX)),
      .upd_taken  (rs_taken),
      .upd_tag    (rs_pc[15:IDX_W+1]),
      .upd_target (rs_target),
      .vld        (e_vld[gi]),
      .tag        (e_tag[gi]),
      .target     (e_tgt[gi]),
      .ctr        (e_ctr[gi])
    );
  end

  // Next PC: redirect beats stall, stall beats prediction, else sequential.
  always_comb begin
    pc_nxt = pc + 16'd2;
    if (redirect)  pc_nxt = rs_next_pc;
    else if (stall) pc_nxt = pc;
    else if (pred)  pc_nxt = pred_tgt;
  end

  // PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RST_PC;
    else      pc <= pc_nxt;
  end

  // Fetch output register: bubble on redirect, hold on stall, else capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fe_q <= '0;
    end else if (redirect) begin
      fe_q <= '0;
    end else if (!stall) begin
      fe_q.valid       <= 1'b1;
      fe_q.ir          <= idin;
      fe_q.pc          <= pc;
      fe_q.pred_taken  <= pred;
      fe_q.pred_target <= pred ? pred_tgt : 16'h0000;
    end
  end

  assign fe_valid       = fe_q.valid;
  assign fe_ir          = fe_q.ir;
  assign fe_pc          = fe_q.pc;
  assign fe_pred_taken  = fe_q.pred_taken;
  assign fe_pred_target = fe_q.pred_target;

endmodule
